transformcoder_sched: RTL and testbench

Sequencing controller for the 4x4 transform-coding datapath (forward transform -> quant -> inverse quant -> inverse transform). It accepts one residual block at a time through a valid/ready handshake and steps the four datapath stages with one-hot stage enables. It holds the finished block until the downstream consumer accepts it. It also tracks block position within a macroblock and latches the macroblock QP, giving QP/6 and QP%6 to the quant stages.

---
 rtl/transformcoder_sched_if.sv | 21 ++
 rtl/transformcoder_sched.sv | 119 +++++++++++
 tb/tb_transformcoder_sched.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/transformcoder_sched_if.sv
// Block handshake bundle between residual source, sequencing scheduler and block consumer.
// Signals: in_valid/in_ready/in_qp/res_load on the accept side, out_valid/out_ready on the handoff side.
// master = source/consumer side, slave = scheduler side.
interface transformcoder_sched_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_qp;
  logic       res_load;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_valid, in_qp, out_ready,
    input  in_ready, res_load, out_valid
  );

  modport slave (
    input  in_valid, in_qp, out_ready,
    output in_ready, res_load, out_valid
  );
endinterface

// File: rtl/transformcoder_sched.sv
// Sequencer for the 4x4 transform-coding datapath: accepts one residual block, steps
// TRAN -> QUANT -> IQUANT -> ITRAN with one-hot stage enables, holds the block until handed off.
// Ports: clk, reset (sync, active-high), enable (run gate), mb_flush, bus (block handshake),
// stage enables, blk_idx, latched QP with QP/6 and QP%6, mb_done pulse, busy.
module transformcoder_sched #(
  parameter int STAGE_CYCLES  = 1,
  parameter int BLOCKS_PER_MB = 16,
  parameter int QP_MAX        = 51
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    mb_flush,
  transformcoder_sched_if.slave   bus,
  output logic                    tran_en,
  output logic                    quant_en,
  output logic                    iquant_en,
  output logic                    itran_en,
  output logic [3:0]              blk_idx,
  output logic [5:0]              qp_cur,
  output logic [3:0]              qp_by_6,
  output logic [2:0]              qp_mod_6,
  output logic                    mb_done,
  output logic                    busy
);

  localparam int            CW       = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STAGE_CYCLES - 1);
  localparam logic [3:0]    BLK_LAST = 4'(BLOCKS_PER_MB - 1);
  localparam logic [5:0]    QP_CLAMP = 6'(QP_MAX);

  typedef enum logic [2:0] {IDLE, TRAN, QUANT, IQUANT, ITRAN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic          handoff;
  logic          stage_state;
  logic          stage_end;
  logic [5:0]    qp_clamped;

  assign bus.in_ready = (state == IDLE) && enable && !mb_flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.res_load = accept;
  assign bus.out_valid = (state == DONE);
  // Handoff needs the run gate too, so a frozen scheduler never completes a transfer.
  assign handoff      = (state == DONE) && bus.out_ready && enable;
  assign busy         = (state != IDLE);
  assign qp_clamped   = (bus.in_qp > QP_CLAMP) ? QP_CLAMP : bus.in_qp;

  assign stage_state  = (state == TRAN) || (state == QUANT) || (state == IQUANT) || (state == ITRAN);
  // A stage only advances on enabled cycles, so gating stretches latency cycle for cycle.
  assign stage_end    = enable && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tran_en   = 1'b0;
    quant_en  = 1'b0;
    iquant_en = 1'b0;
    itran_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = TRAN;
      end
      TRAN: begin
        tran_en = enable;
        if (stage_end) state_nxt = QUANT;
      end
      QUANT: begin
        quant_en = enable;
        if (stage_end) state_nxt = IQUANT;
      end
      IQUANT: begin
        iquant_en = enable;
        if (stage_end) state_nxt = ITRAN;
      end
      ITRAN: begin
        itran_en = enable;
        if (stage_end) state_nxt = DONE;
      end
      DONE: begin
        if (handoff) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (stage_state && enable) begin
      cnt_nxt = stage_end ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      blk_idx  <= 4'd0;
      qp_cur   <= 6'd0;
      qp_by_6  <= 4'd0;
      qp_mod_6 <= 3'd0;
      mb_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mb_done <= handoff && (blk_idx == BLK_LAST);
      if ((state == IDLE) && enable && mb_flush) begin
        blk_idx <= 4'd0;
      end else if (handoff) begin
        blk_idx <= (blk_idx == BLK_LAST) ? 4'd0 : blk_idx + 4'd1;
      end
      // QP is a per-macroblock value: only the first block's in_qp is taken.
      if (accept && (blk_idx == 4'd0)) begin
        qp_cur   <= qp_clamped;
        qp_by_6  <= 4'(qp_clamped / 6'd6);
        qp_mod_6 <= 3'(qp_clamped % 6'd6);
      end
    end
  end

endmodule

// File: tb/tb_transformcoder_sched.sv
// Self-checking bench for transformcoder_sched: randomized blocks against a progress-count
// reference model, plus directed reset, QP latch, backpressure, wrap, gating and flush scenarios.
// A second instance with STAGE_CYCLES=3 checks the stretched stage timing.
module tb_transformcoder_sched;
  localparam int SC = 1;

  logic clk = 1'b0;
  logic reset;
  logic enable, mb_flush;
  logic tran_en, quant_en, iquant_en, itran_en, mb_done, busy;
  logic [3:0] blk_idx, qp_by_6;
  logic [5:0] qp_cur;
  logic [2:0] qp_mod_6;

  logic enable3, mb_flush3;
  logic tran_en3, quant_en3, iquant_en3, itran_en3, mb_done3, busy3;
  logic [3:0] blk_idx3, qp_by_63;
  logic [5:0] qp_cur3;
  logic [2:0] qp_mod_63;

  transformcoder_sched_if bus();
  transformcoder_sched_if bus3();

  transformcoder_sched #(.STAGE_CYCLES(SC), .BLOCKS_PER_MB(16), .QP_MAX(51)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mb_flush(mb_flush), .bus(bus),
    .tran_en(tran_en), .quant_en(quant_en), .iquant_en(iquant_en), .itran_en(itran_en),
    .blk_idx(blk_idx), .qp_cur(qp_cur), .qp_by_6(qp_by_6), .qp_mod_6(qp_mod_6),
    .mb_done(mb_done), .busy(busy)
  );

  transformcoder_sched #(.STAGE_CYCLES(3), .BLOCKS_PER_MB(16), .QP_MAX(51)) dut3 (
    .clk(clk), .reset(reset), .enable(enable3), .mb_flush(mb_flush3), .bus(bus3),
    .tran_en(tran_en3), .quant_en(quant_en3), .iquant_en(iquant_en3), .itran_en(itran_en3),
    .blk_idx(blk_idx3), .qp_cur(qp_cur3), .qp_by_6(qp_by_63), .qp_mod_6(qp_mod_63),
    .mb_done(mb_done3), .busy(busy3)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int mbd_seen = 0;

  // Reference model state: macroblock position, latched QP, pending mb_done pulse.
  logic [3:0] m_blk;
  logic [5:0] m_qp;
  bit         m_mbd;

  function automatic logic [25:0] obs();
    return {bus.in_ready, bus.res_load, tran_en, quant_en, iquant_en, itran_en,
            bus.out_valid, busy, mb_done, blk_idx, qp_cur, qp_by_6, qp_mod_6};
  endfunction

  function automatic logic [25:0] expv(bit ir, bit rl, logic [3:0] stg, bit ov, bit bsy, bit mbd);
    return {ir, rl, stg, ov, bsy, mbd, m_blk, m_qp, 4'(m_qp / 6), 3'(m_qp % 6)};
  endfunction

  // Runs one block from an IDLE cycle (entered at posedge+1) through handoff and one idle
  // cycle. Gating drops enable for cycles gate_at..gate_at+gate_len-1 after the accept edge;
  // out_ready stays low for ready_delay enabled DONE cycles.
  task automatic run_block(input logic [5:0] qp, input int gate_at, input int gate_len,
                           input int ready_delay, output int rise, output int ov_cycles);
    int p, wn, cyc;
    bit done, en;
    logic [3:0] stg;
    logic [25:0] e;
    bus.in_valid = 1'b1; bus.in_qp = qp; enable = 1'b1; mb_flush = 1'b0;
    bus.out_ready = 1'($urandom);
    #1;
    e = expv(1, 1, 4'b0, 0, 0, m_mbd);
    n_chk++;
    if (obs() !== e) $display("FAIL accept: got %h want %h", obs(), e); else n_pass++;
    @(posedge clk);
    if (m_blk == 4'd0) m_qp = (qp > 6'd51) ? 6'd51 : qp;
    m_mbd = 0;
    #1;
    p = 0; wn = 0; done = 0; rise = -1; ov_cycles = 0;
    for (cyc = 1; cyc < 200 && !done; cyc++) begin
      en = !(cyc >= gate_at && cyc < gate_at + gate_len);
      enable = en;
      bus.in_valid = 1'($urandom);
      bus.in_qp = 6'($urandom);
      mb_flush = 1'($urandom);
      bus.out_ready = (p >= 4 * SC) ? (wn >= ready_delay) : 1'($urandom);
      stg = (p < 4 * SC && en) ? (4'b1000 >> (p / SC)) : 4'b0000;
      #1;
      e = expv(0, 0, stg, p >= 4 * SC, 1, 0);
      n_chk++;
      if (obs() !== e) $display("FAIL cycle %0d: got %h want %h", cyc, obs(), e); else n_pass++;
      if (p >= 4 * SC) begin
        ov_cycles++;
        if (rise < 0) rise = cyc;
      end
      @(posedge clk); #1;
      if (en) begin
        if (p < 4 * SC) p++;
        else if (bus.out_ready) done = 1;
        else wn++;
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL handoff_timeout: got none want handoff within 200 cycles");
    end
    m_mbd = (m_blk == 4'd15);
    m_blk = (m_blk == 4'd15) ? 4'd0 : m_blk + 4'd1;
    enable = 1'b1; bus.in_valid = 1'b0; mb_flush = 1'b0; bus.out_ready = 1'b0;
    #1;
    e = expv(1, 0, 4'b0, 0, 0, m_mbd);
    n_chk++;
    if (obs() !== e) $display("FAIL post_handoff: got %h want %h", obs(), e); else n_pass++;
    if (mb_done) mbd_seen++;
    @(posedge clk); #1;
    m_mbd = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; mb_flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_qp = 6'd0; bus.out_ready = 1'b0;
    enable3 = 1'b0; mb_flush3 = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_qp = 6'd0; bus3.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (obs() !== 26'd0) $display("FAIL reset_state: got %h want 0", obs()); else n_pass++;
    n_chk++;
    if ({bus3.out_valid, busy3, blk_idx3, qp_cur3} !== 12'd0)
      $display("FAIL reset_state3: got %h want 0", {bus3.out_valid, busy3, blk_idx3, qp_cur3});
    else n_pass++;
    reset = 1'b0;
    m_blk = 4'd0; m_qp = 6'd0; m_mbd = 0;
    @(posedge clk);
    enable = 1'b1;
    #1;
    n_chk++;
    if (obs() !== expv(1, 0, 4'b0, 0, 0, 0)) $display("FAIL idle_ready: got %h want %h", obs(), expv(1, 0, 4'b0, 0, 0, 0));
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    bus.in_valid = 1'b1; mb_flush = 1'b1; enable = 1'b1; bus.in_qp = 6'($urandom);
    #1;
    n_chk++;
    if ({bus.in_ready, bus.res_load} !== 2'b00)
      $display("FAIL flush_block_accept: got %b want 00", {bus.in_ready, bus.res_load});
    else n_pass++;
    @(posedge clk);
    m_blk = 4'd0;
    #1;
    bus.in_valid = 1'b0; mb_flush = 1'b0;
    #1;
    n_chk++;
    if (obs() !== expv(1, 0, 4'b0, 0, 0, 0)) $display("FAIL flush_result: got %h want %h", obs(), expv(1, 0, 4'b0, 0, 0, 0));
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int rise, ovc;
    run_block(6'd28, 0, 0, 0, rise, ovc);
    n_chk++;
    if (rise !== 5) $display("FAIL single_latency: got %0d want 5", rise); else n_pass++;
    n_chk++;
    if (ovc !== 1) $display("FAIL single_ov_cycles: got %0d want 1", ovc); else n_pass++;
    n_chk++;
    if ({qp_cur, qp_by_6, qp_mod_6, blk_idx} !== {6'd28, 4'd4, 3'd4, 4'd1})
      $display("FAIL single_qp: got %h want %h", {qp_cur, qp_by_6, qp_mod_6, blk_idx}, {6'd28, 4'd4, 3'd4, 4'd1});
    else n_pass++;
  endtask

  task automatic test_qp_ignore();
    int rise, ovc;
    test_flush();
    run_block(6'd20, 0, 0, 0, rise, ovc);
    run_block(6'd40, 0, 0, 0, rise, ovc);
    n_chk++;
    if ({qp_cur, qp_by_6, qp_mod_6, blk_idx} !== {6'd20, 4'd3, 3'd2, 4'd2})
      $display("FAIL qp_ignore: got %h want %h", {qp_cur, qp_by_6, qp_mod_6, blk_idx}, {6'd20, 4'd3, 3'd2, 4'd2});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int rise, ovc;
    run_block(6'($urandom), 0, 0, 3, rise, ovc);
    n_chk++;
    if (rise !== 5 || ovc !== 4) $display("FAIL backpressure: got rise %0d ov %0d want rise 5 ov 4", rise, ovc);
    else n_pass++;
  endtask

  task automatic test_mb_wrap();
    int rise, ovc;
    test_flush();
    mbd_seen = 0;
    for (int i = 0; i < 16; i++)
      run_block(6'($urandom), $urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(0, 1), rise, ovc);
    n_chk++;
    if (mbd_seen !== 1 || blk_idx !== 4'd0) $display("FAIL mb_wrap: got pulses %0d idx %0d want 1 and 0", mbd_seen, blk_idx);
    else n_pass++;
    run_block(6'd60, 0, 0, 0, rise, ovc);
    n_chk++;
    if ({qp_cur, qp_by_6, qp_mod_6} !== {6'd51, 4'd8, 3'd3})
      $display("FAIL qp_clamp: got %h want %h", {qp_cur, qp_by_6, qp_mod_6}, {6'd51, 4'd8, 3'd3});
    else n_pass++;
  endtask

  task automatic test_gating();
    int rise, ovc;
    run_block(6'($urandom), 2, 2, 0, rise, ovc);
    n_chk++;
    if (rise !== 7) $display("FAIL gated_latency: got %0d want 7", rise); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int rise, ovc, bad;
    bus.in_valid = 1'b1; bus.in_qp = 6'($urandom); enable = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_chk++;
    if (iquant_en !== 1'b1) $display("FAIL reach_iquant: got %b want 1", iquant_en); else n_pass++;
    reset = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (obs() !== 26'd0) $display("FAIL reset_abort: got %h want 0", obs()); else n_pass++;
    reset = 1'b0; enable = 1'b1; bus.out_ready = 1'b1;
    m_blk = 4'd0; m_qp = 6'd0; m_mbd = 0;
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid || busy || mb_done) bad++;
    end
    n_chk++;
    if (bad !== 0) $display("FAIL abort_no_output: got %0d active cycles want 0", bad); else n_pass++;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) run_block(6'($urandom), 0, 0, 0, rise, ovc);
    n_chk++;
    if (blk_idx !== 4'd5) $display("FAIL pre_flush_idx: got %0d want 5", blk_idx); else n_pass++;
    test_flush();
  endtask

  task automatic test_latency3();
    int rise, bad;
    int cnt [4];
    cnt = '{0, 0, 0, 0};
    enable3 = 1'b1; bus3.in_valid = 1'b1; bus3.in_qp = 6'd33; bus3.out_ready = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    rise = -1; bad = 0;
    for (int c = 1; c < 40 && rise < 0; c++) begin
      if (tran_en3) cnt[0]++;
      if (quant_en3) cnt[1]++;
      if (iquant_en3) cnt[2]++;
      if (itran_en3) cnt[3]++;
      if ($countones({tran_en3, quant_en3, iquant_en3, itran_en3}) > 1) bad++;
      if (bus3.out_valid) rise = c;
      @(posedge clk); #1;
    end
    n_chk++;
    if (rise !== 13) $display("FAIL latency3: got %0d want 13", rise); else n_pass++;
    n_chk++;
    if (cnt[0] !== 3 || cnt[1] !== 3 || cnt[2] !== 3 || cnt[3] !== 3 || bad !== 0)
      $display("FAIL stage3_enables: got %0d %0d %0d %0d overlap %0d want 3 3 3 3 overlap 0",
               cnt[0], cnt[1], cnt[2], cnt[3], bad);
    else n_pass++;
    n_chk++;
    if ({bus3.out_valid, blk_idx3, qp_cur3} !== {1'b0, 4'd1, 6'd33})
      $display("FAIL handoff3: got %h want %h", {bus3.out_valid, blk_idx3, qp_cur3}, {1'b0, 4'd1, 6'd33});
    else n_pass++;
    bus3.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int rise, ovc;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0) test_flush();
      run_block(6'($urandom), $urandom_range(1, 7), $urandom_range(0, 3), $urandom_range(0, 3), rise, ovc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_qp_ignore();
    test_backpressure();
    test_mb_wrap();
    test_gating();
    test_reset_mid();
    test_latency3();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
